// File: rtl/inst_mem_pkg.sv
// Shared definitions for the run-time loadable instruction memory:
// controller states, fetch fault bit positions and the default NOP word.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_array.sv
// Single write / single read synchronous RAM with a registered read port.
// The read register only updates on a read enable so its value holds between fetches.
module inst_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read-data value: new word on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with a streaming program-load port and a one-cycle fetch port
// that flags misaligned and out-of-range PCs instead of returning stale data.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_last,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     load_err,
    output logic                     ready,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_pc,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        instruction,
    output logic [1:0]               fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              fvalid_q, fvalid_d;
    logic [1:0]        fault_q, fault_d;
    logic              we_s;
    logic              accept_s;
    logic              full_s;
    logic [IW-1:0]     idx_s;
    logic [DATA_W-1:0] rdata_s;

    assign idx_s    = fetch_pc[ADDR_W-1:2];
    assign accept_s = (state_q == RUN) && fetch_req && !load_start;
    // The counter doubles as write index; reaching DEPTH means any further word overflows.
    assign full_s   = (count_q == CW'(DEPTH));

    // Load controller: state transitions, write index/count and sticky overflow flag.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_s    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = EMPTY;
                end
            end
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (load_valid) begin
                    if (full_s) begin
                        err_d = 1'b1;
                    end else begin
                        we_s    = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    if (load_last) begin
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Fetch response: faults are decided at accept time and held until the next accept.
    always_comb begin
        fvalid_d = accept_s;
        fault_d  = fault_q;
        if (accept_s) begin
            fault_d[FAULT_MISALIGN] = (fetch_pc[1:0] != 2'b00);
            fault_d[FAULT_RANGE]    = (idx_s >= IW'(DEPTH));
        end else begin
            fault_d = fault_q;
        end
    end

    // Controller and fetch-response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            fault_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fault_q  <= fault_d;
        end
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we_s),
        .waddr   (count_q[AW-1:0]),
        .wdata   (load_data),
        .re      (accept_s),
        .raddr   (idx_s[AW-1:0]),
        .rdata   (rdata_s)
    );

    assign load_count  = count_q;
    assign load_err    = err_q;
    assign ready       = (state_q == RUN);
    assign fetch_valid = fvalid_q;
    assign fetch_fault = fault_q;
    assign instruction = (fault_q != 2'b00) ? NOP_WORD : rdata_s;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed, table-driven bench for inst_mem_loader: a DEPTH=64 instance for load,
// fetch, fault, reload and reset cases, and a DEPTH=4 instance for overflow.
module tb_inst_mem_loader;

    logic clk;
    logic reset_n;

    logic        load_start, load_valid, load_last, fetch_req;
    logic [31:0] load_data, fetch_pc;
    logic [6:0]  load_count;
    logic        load_err, ready, fetch_valid;
    logic [31:0] instruction;
    logic [1:0]  fetch_fault;

    logic        b_load_start, b_load_valid, b_load_last, b_fetch_req;
    logic [31:0] b_load_data, b_fetch_pc;
    logic [2:0]  b_load_count;
    logic        b_load_err, b_ready, b_fetch_valid;
    logic [31:0] b_instruction;
    logic [1:0]  b_fetch_fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } fvec_t;

    fvec_t       vecs [10];
    logic [31:0] prog [4];

    inst_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_count(load_count), .load_err(load_err),
        .ready(ready), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .instruction(instruction), .fetch_fault(fetch_fault)
    );

    inst_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_last(b_load_last), .load_count(b_load_count), .load_err(b_load_err),
        .ready(b_ready), .fetch_req(b_fetch_req), .fetch_pc(b_fetch_pc),
        .fetch_valid(b_fetch_valid), .instruction(b_instruction), .fetch_fault(b_fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020;
        prog[3] = 32'hAC0A_0000;

        vecs[0] = '{32'h0000_0000, 32'h2008_0005, 2'b00};
        vecs[1] = '{32'h0000_0004, 32'h2009_0003, 2'b00};
        vecs[2] = '{32'h0000_0008, 32'h0109_5020, 2'b00};
        vecs[3] = '{32'h0000_000C, 32'hAC0A_0000, 2'b00};
        vecs[4] = '{32'h0000_0006, 32'h0000_0000, 2'b01};
        vecs[5] = '{32'h0000_0100, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'h0000_0104, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b10};
        vecs[8] = '{32'h0000_0004, 32'h2009_0003, 2'b00};
        vecs[9] = '{32'h0000_0102, 32'h0000_0000, 2'b11};

        reset_n    = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
        fetch_req  = 1'b0; fetch_pc = 32'h0;
        b_load_start = 1'b0; b_load_valid = 1'b0; b_load_last = 1'b0; b_load_data = 32'h0;
        b_fetch_req  = 1'b0; b_fetch_pc = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_fault", {30'd0, fetch_fault}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_count", {25'd0, load_count}, 32'd0);
        reset_n = 1'b1;

        // Fetch in EMPTY is ignored
        fetch_req = 1'b1; fetch_pc = 32'h0;
        @(negedge clk);
        check("empty_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("empty_instr", instruction, 32'h0);

        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("load_ready", {31'd0, ready}, 32'd0);
        for (int w = 0; w < 4; w++) begin
            load_valid = 1'b1; load_data = prog[w]; load_last = (w == 3);
            @(negedge clk);
            check("load_fvalid", {31'd0, fetch_valid}, 32'd0);
        end
        load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
        check("load_instr_hold", instruction, 32'h0);
        check("load_count4", {25'd0, load_count}, 32'd4);
        check("run_ready", {31'd0, ready}, 32'd1);

        // Back-to-back fetch table
        for (int i = 0; i < 10; i++) begin
            fetch_req = 1'b1; fetch_pc = vecs[i].pc;
            @(negedge clk);
            check($sformatf("fetch%0d_valid", i), {31'd0, fetch_valid}, 32'd1);
            check($sformatf("fetch%0d_instr", i), instruction, vecs[i].instr);
            check($sformatf("fetch%0d_fault", i), {30'd0, fetch_fault}, {30'd0, vecs[i].fault});
        end
        fetch_req = 1'b0;
        @(negedge clk);
        check("idle_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("idle_fault_hold", {30'd0, fetch_fault}, 32'd3);
        check("idle_instr_hold", instruction, 32'h0);

        // Reload race: fetch in N, load_start + fetch_req in N+1
        fetch_req = 1'b1; fetch_pc = 32'h4;
        @(negedge clk);
        check("race_fvalid", {31'd0, fetch_valid}, 32'd1);
        check("race_instr", instruction, 32'h2009_0003);
        check("race_ready_n1", {31'd0, ready}, 32'd1);
        load_start = 1'b1; fetch_pc = 32'h8;
        @(negedge clk);
        check("race_ready_n2", {31'd0, ready}, 32'd0);
        check("race_no_answer", {31'd0, fetch_valid}, 32'd0);
        check("race_instr_hold", instruction, 32'h2009_0003);
        load_start = 1'b0;

        // Partial load then async reset mid-load
        for (int w = 0; w < 2; w++) begin
            load_valid = 1'b1; load_data = 32'h1111_0000 + 32'(w); load_last = 1'b0;
            @(negedge clk);
        end
        check("part_count", {25'd0, load_count}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_ready", {31'd0, ready}, 32'd0);
        check("mrst_count", {25'd0, load_count}, 32'd0);
        check("mrst_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("mrst_instr", instruction, 32'h0);
        check("mrst_fault", {30'd0, fetch_fault}, 32'd0);
        load_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fetch_pc = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_rst_fvalid", {31'd0, fetch_valid}, 32'd0);
        end
        fetch_req = 1'b0;

        // New load with a load_start that collides with load_valid
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'h9999_0000;
        @(negedge clk);
        load_start = 1'b1; load_data = 32'hDEAD_0000;
        @(negedge clk);
        load_start = 1'b0;
        check("restart_count", {25'd0, load_count}, 32'd0);
        load_data = 32'hCAFE_0001;
        @(negedge clk);
        load_data = 32'hCAFE_0002; load_last = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        check("reload_count", {25'd0, load_count}, 32'd2);
        check("reload_ready", {31'd0, ready}, 32'd1);
        fetch_req = 1'b1; fetch_pc = 32'h4;
        @(negedge clk);
        check("reload_w1", instruction, 32'hCAFE_0002);
        fetch_pc = 32'h0;
        @(negedge clk);
        check("reload_w0", instruction, 32'hCAFE_0001);
        fetch_req = 1'b0;

        // Overflow on the DEPTH=4 instance
        b_load_start = 1'b1;
        @(negedge clk);
        b_load_start = 1'b0;
        for (int w = 0; w < 6; w++) begin
            b_load_valid = 1'b1; b_load_data = 32'hB000_0000 + 32'(w); b_load_last = (w == 5);
            @(negedge clk);
            if (w == 3) begin
                check("ovf_err_early", {31'd0, b_load_err}, 32'd0);
                check("ovf_count_full", {29'd0, b_load_count}, 32'd4);
            end
        end
        b_load_valid = 1'b0; b_load_last = 1'b0;
        check("ovf_err", {31'd0, b_load_err}, 32'd1);
        check("ovf_count", {29'd0, b_load_count}, 32'd4);
        check("ovf_ready", {31'd0, b_ready}, 32'd1);
        b_fetch_req = 1'b1; b_fetch_pc = 32'hC;
        @(negedge clk);
        check("ovf_w3", b_instruction, 32'hB000_0003);
        check("ovf_w3_fault", {30'd0, b_fetch_fault}, 32'd0);
        b_fetch_pc = 32'h0;
        @(negedge clk);
        check("ovf_w0", b_instruction, 32'hB000_0000);
        b_fetch_pc = 32'h10;
        @(negedge clk);
        check("ovf_range_fault", {30'd0, b_fetch_fault}, 32'd2);
        check("ovf_range_instr", b_instruction, 32'h0);
        b_fetch_req = 1'b0; b_load_start = 1'b1;
        @(negedge clk);
        b_load_start = 1'b0;
        check("ovf_err_clear", {31'd0, b_load_err}, 32'd0);
        check("ovf_count_clear", {29'd0, b_load_count}, 32'd0);
        check("ovf_reload_ready", {31'd0, b_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
